// File: rtl/pio_gen2_if.sv
// Avalon-MM slave bus bundle for pio_gen2: register select, write strobe and data,
// plus the combinational read data returned by the slave.
interface pio_gen2_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_gen2.sv
// Parametrised Avalon-MM GPIO: per-bit direction, synchronised inputs, edge capture and masked irq.
// Optional OUTSET/OUTCLEAR registers at addresses 4/5 are built when PIO_GEN2_SETCLR_EN is defined.
module pio_gen2 #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter int unsigned      EDGE_TYPE = 0,
  parameter int unsigned      IRQ_TYPE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  pio_gen2_if.slave        bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA     = 3'd0,
    REG_DIR      = 3'd1,
    REG_IRQMASK  = 3'd2,
    REG_EDGECAP  = 3'd3,
    REG_OUTSET   = 3'd4,
    REG_OUTCLEAR = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] s1, s2, s3;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_sel;
  logic             wr_en;
  logic             irq_src;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  assign out_port = data_out;
  assign oe_port  = dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = s2 & ~s3;
      1:       edge_hit = ~s2 & s3;
      default: edge_hit = s2 ^ s3;
    endcase
  end

  always_comb begin
    cap_clr = '0;
    if (wr_en && bus.address == REG_EDGECAP) cap_clr = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irq_mask <= '0;
    end else if (wr_en) begin
      case (bus.address)
        REG_DATA:     data_out <= wdata;
        REG_DIR:      dir      <= wdata;
        REG_IRQMASK:  irq_mask <= wdata;
`ifdef PIO_GEN2_SETCLR_EN
        REG_OUTSET:   data_out <= data_out | wdata;
        REG_OUTCLEAR: data_out <= data_out & ~wdata;
`endif
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as its clear must survive, so set is OR-ed in after the clear.
  always_ff @(posedge clk) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
  end

  assign irq_src = (IRQ_TYPE == 1) ? |(edge_cap & irq_mask) : |(s2 & irq_mask);

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= irq_src;
  end

  always_comb begin
    rd_sel = '0;
    case (bus.address)
      REG_DATA:    rd_sel = (s2 & ~dir) | (data_out & dir);
      REG_DIR:     rd_sel = dir;
      REG_IRQMASK: rd_sel = irq_mask;
      REG_EDGECAP: rd_sel = edge_cap;
      default:     rd_sel = '0;
    endcase
  end

  assign bus.readdata = 32'(rd_sel);

endmodule

// File: tb/tb_pio_gen2.sv
// Directed bench for pio_gen2: stimulus queues expected values, a negedge monitor pops and compares.
// Two instances run side by side: edge-type irq (dut) and level-type irq (dut_lvl).
module tb_pio_gen2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;

  logic [7:0]  out_port, oe_port, out_port_l, oe_port_l;
  logic        irq, irq_l;

  always #5 clk = ~clk;

  pio_gen2_if bus_e ();
  pio_gen2_if bus_l ();

  assign bus_e.address    = address;
  assign bus_e.chipselect = chipselect;
  assign bus_e.write_n    = write_n;
  assign bus_e.writedata  = writedata;
  assign bus_l.address    = address;
  assign bus_l.chipselect = chipselect;
  assign bus_l.write_n    = write_n;
  assign bus_l.writedata  = writedata;

  pio_gen2 #(
    .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(0), .IRQ_TYPE(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus_e), .in_port(in_port),
    .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  pio_gen2 #(
    .WIDTH(8), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F), .EDGE_TYPE(0), .IRQ_TYPE(0)
  ) dut_lvl (
    .clk(clk), .reset(reset), .bus(bus_l), .in_port(in_port),
    .out_port(out_port_l), .oe_port(oe_port_l), .irq(irq_l)
  );

  typedef enum int {K_RD, K_OUT, K_OE, K_IRQ, K_LIRQ} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Monitor: compare everything queued for this cycle at the falling edge.
  always @(negedge clk) begin
    while (q.size() != 0) begin
      item_t       it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.kind)
        K_RD:    act = bus_e.readdata;
        K_OUT:   act = {24'h0, out_port};
        K_OE:    act = {24'h0, oe_port};
        K_IRQ:   act = {31'h0, irq};
        default: act = {31'h0, irq_l};
      endcase
      n_cmp++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic push(input kind_e k, input logic [2:0] a, input logic [31:0] e, input string nm);
    item_t it;
    if (k == K_RD) address = a;
    it.kind = k;
    it.exp  = e;
    it.name = nm;
    q.push_back(it);
  endtask

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles
    step();
    step();
    reset = 1'b0;
    push(K_OUT, 0, 32'hA5, "rst_out");
    push(K_OE, 0, 32'h0F, "rst_oe");
    push(K_IRQ, 0, 32'h0, "rst_irq");
    push(K_LIRQ, 0, 32'h0, "rst_irq_lvl");
    push(K_RD, 3'd2, 32'h0, "rst_irqmask");
    sync();
    step();
    push(K_RD, 3'd3, 32'h0, "rst_edgecap");
    sync();
    step();
    push(K_RD, 3'd0, 32'h05, "rst_data_read");
    sync();

    // Mixed direction read, upper writedata bits ignored
    wr(3'd1, 32'hFFFF_FFF0);
    push(K_OE, 0, 32'hF0, "dir_oe_next_cycle");
    sync();
    wr(3'd0, 32'hFFFF_FF3C);
    push(K_OUT, 0, 32'h3C, "data_out_write");
    sync();
    in_port = 8'h5A;
    step();
    step();
    step();
    push(K_RD, 3'd0, 32'h0000_003A, "mixed_dir_read");
    sync();
    step();
    push(K_RD, 3'd3, 32'h5A, "edgecap_rising_bits");
    sync();
    in_port = 8'h00;
    step();
    step();
    step();
    push(K_RD, 3'd3, 32'h5A, "falling_not_captured");
    sync();
    wr(3'd3, 32'hFF);
    push(K_RD, 3'd3, 32'h0, "w1c_clear_all");
    sync();

    // Rising-edge capture and edge irq timing
    wr(3'd2, 32'h01);
    in_port = 8'h01;
    step();
    step();
    push(K_IRQ, 0, 32'h0, "edge_irq_not_yet");
    push(K_RD, 3'd3, 32'h0, "edgecap_cycle2");
    sync();
    step();
    push(K_RD, 3'd3, 32'h01, "edgecap_cycle3");
    push(K_IRQ, 0, 32'h0, "edge_irq_cycle3");
    sync();
    step();
    push(K_IRQ, 0, 32'h1, "edge_irq_cycle4");
    push(K_LIRQ, 0, 32'h1, "lvl_irq_bit0");
    sync();
    wr(3'd3, 32'h01);
    push(K_RD, 3'd3, 32'h0, "edgecap_cleared");
    push(K_IRQ, 0, 32'h1, "irq_one_cycle_lag");
    sync();
    step();
    push(K_IRQ, 0, 32'h0, "irq_after_clear");
    sync();

    // Clear write collides with a new edge on bit 1: set wins
    in_port = 8'h03;
    step();
    step();
    wr(3'd3, 32'h02);
    push(K_RD, 3'd3, 32'h02, "clear_edge_collision");
    sync();
    wr(3'd3, 32'h00);
    push(K_RD, 3'd3, 32'h02, "w0_no_effect");
    sync();
    wr(3'd3, 32'hFF);

    // Level irq on bit 7
    wr(3'd2, 32'h80);
    in_port = 8'h83;
    step();
    step();
    push(K_LIRQ, 0, 32'h0, "lvl_irq_rise_early");
    sync();
    step();
    push(K_LIRQ, 0, 32'h1, "lvl_irq_rise");
    sync();
    in_port = 8'h03;
    step();
    step();
    push(K_LIRQ, 0, 32'h1, "lvl_irq_fall_early");
    sync();
    step();
    push(K_LIRQ, 0, 32'h0, "lvl_irq_fall");
    sync();
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h00);
    in_port = 8'h83;
    step();
    step();
    step();
    step();
    push(K_LIRQ, 0, 32'h0, "lvl_irq_masked");
    push(K_IRQ, 0, 32'h0, "edge_irq_masked");
    sync();

    // Mask readback, unused addresses
    wr(3'd2, 32'h0000_01FF);
    push(K_RD, 3'd2, 32'hFF, "irqmask_readback");
    sync();
    step();
    push(K_IRQ, 0, 32'h1, "edge_irq_pending_bit7");
    sync();
    wr(3'd6, 32'hFFFF_FFFF);
    push(K_RD, 3'd6, 32'h0, "addr6_reads_zero");
    push(K_OUT, 0, 32'h3C, "addr6_write_ignored");
    sync();
    step();
    push(K_RD, 3'd7, 32'h0, "addr7_reads_zero");
    sync();

    // Set/clear registers
    wr(3'd0, 32'h11);
    push(K_OUT, 0, 32'h11, "setclr_base");
    sync();
    wr(3'd4, 32'h06);
`ifdef PIO_GEN2_SETCLR_EN
    push(K_OUT, 0, 32'h17, "outset");
`else
    push(K_OUT, 0, 32'h11, "outset_absent");
`endif
    push(K_RD, 3'd4, 32'h0, "addr4_reads_zero");
    sync();
    wr(3'd5, 32'h13);
`ifdef PIO_GEN2_SETCLR_EN
    push(K_OUT, 0, 32'h04, "outclear");
`else
    push(K_OUT, 0, 32'h11, "outclear_absent");
`endif
    push(K_RD, 3'd5, 32'h0, "addr5_reads_zero");
    sync();

    // Reset with a capture and irq pending
    in_port = 8'h8F;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(K_OUT, 0, 32'hA5, "rst2_out");
    push(K_OE, 0, 32'h0F, "rst2_oe");
    push(K_IRQ, 0, 32'h0, "rst2_irq");
    push(K_RD, 3'd3, 32'h0, "rst2_edgecap");
    sync();
    step();
    push(K_RD, 3'd3, 32'h0, "no_edge_after_reset");
    sync();
    step();
    step();
    push(K_RD, 3'd3, 32'h8F, "recapture_after_reset");
    push(K_IRQ, 0, 32'h0, "rst2_mask_cleared");
    sync();
    step();
    push(K_RD, 3'd0, 32'h85, "data_read_after_reset");
    sync();

    step();
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
